fcp_tx_engine: RTL
==================

// Module: fcp_tx_engine
// PURPOSE
//  Parametrised FCP single-wire transmitter: ping frames, or multi-byte data frames of 1..MAX_BYTES
//  bytes followed by a bit-serial CRC-8 byte. Sits between the FCP protocol FSM and the line driver,
//  and has a valid/ready request port. UI length, sync length, ping length and CRC polynomial are set by parameters.
// PARAMETERS
//  UI_CYCLE   20     clocks per UI; multiple of 4, >=8; quarter-UI Q = UI_CYCLE/4
//  MAX_BYTES  4      max payload bytes per data frame
//  SYNC_Q     2      quarter-UI segments per SYNC phase (1..7)
//  PING_UI    16     UIs the line is held high in a ping
//  CRC_POLY   8'h39  CRC-8 polynomial; MSB-first, init 8'h00, no reflection, no final xor
// PORTS
//  clk       in   1               clock
//  rst       in   1               synchronous reset, active-high
//  tx_valid  in   1               request valid
//  tx_ready  out  1               engine idle, request accepted when tx_valid&tx_ready
//  tx_type   in   1               0: ping  1: data frame
//  tx_len    in   $clog2(MAX_BYTES+1)  payload byte count (data only)
//  tx_data   in   8*MAX_BYTES     payload; byte0=[7:0] sent first
//  tx_abort  in   1               abort current frame (only with FCP_TX_ABORT_EN)
//  data_out  out  1               serial line
//  tx_busy   out  1               frame in progress
//  tx_done   out  1               1-cycle pulse at frame end
//  tx_err    out  1               1-cycle pulse: bad tx_len (or abort)
// BEHAVIOUR
//  - Reset: state IDLE; data_out=0, tx_busy=0, tx_done=0, tx_err=0, tx_ready=0 while rst high, else tx_ready=(state==IDLE).
//  - Accept edge: latch tx_type/tx_len/tx_data, clear CRC. State leaves IDLE at the same edge. First data_out change on the next edge.
//  - Data request with tx_len==0 or tx_len>MAX_BYTES: nothing sent. State stays IDLE. tx_err pulses the next cycle. tx_ready stays high.
//  - All outputs are registered. States: IDLE, SYNC, BIT, PING.
//  - SYNC: SYNC_Q segments of Q clocks. data_out toggles at the start of every segment. Exit goes to BIT if bytes are left, else PING.
//  - BIT: 9 UIs per byte. 8 data bits MSB first, then odd parity (~^byte). data_out = bit value for the whole UI.
//    Each data bit is shifted into the CRC when it is sent.
//    After the parity bit, go to SYNC. The byte order is payload bytes 0..tx_len-1, then the CRC byte. The CRC byte is not fed into the CRC.
//  - PING: data_out=1 for PING_UI*UI_CYCLE clocks. The following edge sets data_out=0, state IDLE, and tx_done=1 for 1 cycle.
//  - Ping request: IDLE->PING directly.
//    Data request: IDLE->SYNC->(BIT->SYNC) x (tx_len+1)->PING.
//  - Frame length in clocks. Data frame: (N+1)*(SYNC_Q*Q+9*UI_CYCLE) + SYNC_Q*Q + PING_UI*UI_CYCLE.
//    Ping: PING_UI*UI_CYCLE. Defaults, N=1: 710. Ping: 320.
//  - tx_busy = (state!=IDLE). tx_valid while busy is ignored and not queued.
//  - Counters: cycle counter wraps at UI_CYCLE (or Q in SYNC). The UI/bit counter wraps at 9 in BIT and at PING_UI in PING.
//    The byte counter runs 0..tx_len.
//  - rst mid-frame: IDLE next edge, data_out=0, no tx_done, latched request discarded.
// CONFIGURATION
//  FCP_TX_ABORT_EN defined: the tx_abort port exists.
//   - tx_abort=1 in a non-IDLE state: next edge goes IDLE, data_out=0, tx_err pulses 1 cycle, no tx_done.
//   - tx_abort=1 in IDLE forces tx_ready=0, so no accept happens. No other effect.
//  FCP_TX_ABORT_EN undefined: no tx_abort port. Frames always run to completion.
// TESTING
//  1 Ping: tx_type=0 -> data_out 1 for 320 clks, then 0. tx_done pulses once, 321 clks after accept. tx_busy high throughout.
//  2 Data tx_len=1, byte 0x01 -> SYNC 2x5 toggles; bits 0000_0001 P=0; SYNC; CRC 0x39 bits 0011_1001 P=1; SYNC; ping 320 clks.
//    tx_done at clk 711.
//  3 tx_len=4, data 0x44332211 -> bytes 11,22,33,44,then CRC in order. Reference model checks CRC and parity per byte.
//    Frame length = 5*190+10+320.
//  4 tx_len=0, then tx_len=5 -> no data_out activity; tx_err pulse 1 clk after each accept; tx_ready stays 1.
//  5 rst pulse mid-BIT of byte 1 -> data_out=0, IDLE, no tx_done. A new ping accepted afterwards completes normally.
//  6 (FCP_TX_ABORT_EN) tx_abort during PING -> data_out 0 next edge, tx_err pulse, no tx_done.
//    tx_valid+tx_abort in IDLE -> not accepted.
//  Sweep UI_CYCLE=8/40, SYNC_Q=3, MAX_BYTES=8 on scenarios 2-3.

Source files
------------

// File: rtl/fcp_tx_engine.sv
// FCP single-wire transmitter: ping frames or data frames (payload + CRC-8, odd parity per byte).
// Optional abort input is compiled in with `define FCP_TX_ABORT_EN.
module fcp_tx_engine #(
  parameter int unsigned UI_CYCLE  = 20,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned SYNC_Q    = 2,
  parameter int unsigned PING_UI   = 16,
  parameter logic [7:0]  CRC_POLY  = 8'h39
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  input  logic                             tx_type,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   tx_len,
  input  logic [8*MAX_BYTES-1:0]           tx_data,
`ifdef FCP_TX_ABORT_EN
  input  logic                             tx_abort,
`endif
  output logic                             data_out,
  output logic                             tx_busy,
  output logic                             tx_done,
  output logic                             tx_err
);

  localparam int unsigned Q     = UI_CYCLE / 4;
  localparam int unsigned LenW  = $clog2(MAX_BYTES + 1);
  localparam int unsigned ByteW = LenW + 1;
  localparam int unsigned CycW  = $clog2(UI_CYCLE);
  localparam int unsigned UiMax = (PING_UI > 9) ? PING_UI : 9;
  localparam int unsigned UiW   = $clog2(UiMax);

  typedef enum logic [1:0] {StIdle, StSync, StBit, StPing} state_e;

  state_e                 state_q, state_d;
  logic [CycW-1:0]        cyc_q, cyc_d;
  logic [UiW-1:0]         ui_q, ui_d;
  logic [ByteW-1:0]       byte_q, byte_d;
  logic [LenW-1:0]        len_q, len_d;
  logic [8*MAX_BYTES-1:0] sh_q, sh_d;
  logic [7:0]             crc_q, crc_d;
  logic                   dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   fin_q, fin_d;

  logic       accept;
  logic       payload;
  logic       bytes_left;
  logic [7:0] cur_byte;
  logic       bit_val;
  logic       fb;
  logic [7:0] crc_nx;

`ifdef FCP_TX_ABORT_EN
  assign tx_ready = !rst && (state_q == StIdle) && !tx_abort;
`else
  assign tx_ready = !rst && (state_q == StIdle);
`endif
  assign accept   = tx_valid && tx_ready;
  assign data_out = dout_q;
  assign tx_busy  = (state_q != StIdle);
  assign tx_done  = done_q;
  assign tx_err   = err_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    ui_d       = ui_q;
    byte_d     = byte_q;
    len_d      = len_q;
    sh_d       = sh_q;
    crc_d      = crc_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    fin_d      = fin_q;
    // Byte index len_q is the CRC byte; it is sent but never fed back into the CRC.
    payload    = byte_q < {1'b0, len_q};
    bytes_left = byte_q <= {1'b0, len_q};
    cur_byte   = payload ? sh_q[7:0] : crc_q;
    bit_val    = cur_byte[3'd7 - ui_q[2:0]];
    fb         = crc_q[7] ^ bit_val;
    crc_nx     = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);

    unique case (state_q)
      StIdle: begin
        dout_d = 1'b0;
        fin_d  = 1'b0;
        if (accept) begin
          cyc_d  = '0;
          ui_d   = '0;
          byte_d = '0;
          crc_d  = 8'h00;
          len_d  = tx_len;
          sh_d   = tx_data;
          if (!tx_type) begin
            state_d = StPing;
          end else if (tx_len == '0 || tx_len > LenW'(MAX_BYTES)) begin
            err_d = 1'b1;
          end else begin
            state_d = StSync;
          end
        end
      end
      StSync: begin
        if (cyc_q == '0) dout_d = ~dout_q;
        if (cyc_q == CycW'(Q - 1)) begin
          cyc_d = '0;
          if (ui_q == UiW'(SYNC_Q - 1)) begin
            ui_d    = '0;
            state_d = bytes_left ? StBit : StPing;
          end else begin
            ui_d = ui_q + UiW'(1);
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StBit: begin
        if (cyc_q == '0) begin
          if (ui_q == UiW'(8)) begin
            dout_d = ~^cur_byte;
          end else begin
            dout_d = bit_val;
            if (payload) crc_d = crc_nx;
          end
        end
        if (cyc_q == CycW'(UI_CYCLE - 1)) begin
          cyc_d = '0;
          if (ui_q == UiW'(8)) begin
            ui_d    = '0;
            byte_d  = byte_q + ByteW'(1);
            if (payload) sh_d = sh_q >> 8;
            state_d = StSync;
          end else begin
            ui_d = ui_q + UiW'(1);
          end
        end else begin
          cyc_d = cyc_q + CycW'(1);
        end
      end
      StPing: begin
        // fin_q marks the extra edge after the high period that closes the frame.
        if (fin_q) begin
          dout_d  = 1'b0;
          done_d  = 1'b1;
          fin_d   = 1'b0;
          state_d = StIdle;
        end else begin
          dout_d = 1'b1;
          if (cyc_q == CycW'(UI_CYCLE - 1)) begin
            cyc_d = '0;
            if (ui_q == UiW'(PING_UI - 1)) begin
              ui_d  = '0;
              fin_d = 1'b1;
            end else begin
              ui_d = ui_q + UiW'(1);
            end
          end else begin
            cyc_d = cyc_q + CycW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef FCP_TX_ABORT_EN
    if (tx_abort && state_q != StIdle) begin
      state_d = StIdle;
      dout_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
      fin_d   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cyc_q   <= '0;
      ui_q    <= '0;
      byte_q  <= '0;
      len_q   <= '0;
      sh_q    <= '0;
      crc_q   <= 8'h00;
      dout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ui_q    <= ui_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      crc_q   <= crc_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
    end
  end

endmodule
